// File: rtl/pool_div_32s_16u_seq.sv
// pool_div_32s_16u_seq
// Multi-cycle signed/unsigned divider for the average-pool stage.
// It divides a signed accumulated window sum by an unsigned element count.
// The dividend magnitude goes through radix-2 restoring division, one
// quotient bit per cycle. Signs are applied when the result is registered.
// Quotient and remainder both follow the sign of the dividend.
// Valid/ready handshakes on both sides allow one division in flight.

module pool_div_32s_16u_seq #(
   parameter int ID         = 1,
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 16
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DIN0_WIDTH-1:0]   din0,
   input  logic [DIN1_WIDTH-1:0]   din1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DIN0_WIDTH-1:0]   quot,
   output logic [DIN1_WIDTH:0]     rem,
   output logic                    div_zero
);

   localparam int CW = (DIN0_WIDTH > 2) ? $clog2(DIN0_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DIN0_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DIN0_WIDTH-1:0]   dividend_q;
   logic [DIN1_WIDTH-1:0]   divisor_q;
   logic [DIN1_WIDTH:0]     remPart_q;
   logic [CW-1:0]           cnt_q;
   logic                    neg_q;
   logic [DIN0_WIDTH-1:0]   quot_q;
   logic [DIN1_WIDTH:0]     remOut_q;
   logic                    divZero_q;

   logic                    acceptFire;
   logic [DIN0_WIDTH-1:0]   dinMag;
   logic [DIN0_WIDTH-1:0]   satQuot;
   logic [DIN1_WIDTH+1:0]   remShift;
   logic [DIN1_WIDTH:0]     remDiff;
   logic                    quotBit;
   logic [DIN1_WIDTH:0]     remStep;
   logic [DIN0_WIDTH-1:0]   dividendStep;

   // ID is only an instance tag; this empty block keeps it referenced.
   if (ID >= 0) begin : gInstanceTag
   end

   // State register; an asynchronous reset aborts any division in progress.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the handshake outputs decoded purely from the state.
   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      acceptFire = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acceptFire = 1'b1;
               state_d    = (din1 == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand magnitude, the saturated divide-by-zero quotient, and one restoring step.
   // Only the low DIN1_WIDTH+1 bits of the shifted remainder are subtracted.
   // This works because the remainder before the shift is always below the divisor.
   always_comb begin
      dinMag       = din0[DIN0_WIDTH-1] ? -din0 : din0;
      satQuot      = din0[DIN0_WIDTH-1] ? {1'b1, {(DIN0_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DIN0_WIDTH-1){1'b1}}};
      remShift     = {remPart_q, dividend_q[DIN0_WIDTH-1]};
      remDiff      = remShift[DIN1_WIDTH:0] - {1'b0, divisor_q};
      quotBit      = (remShift >= {2'b00, divisor_q});
      remStep      = quotBit ? remDiff : remShift[DIN1_WIDTH:0];
      dividendStep = {dividend_q[DIN0_WIDTH-2:0], quotBit};
   end

   // Datapath: operands are latched at acceptance.
   // Quotient bits shift into the dividend register as it empties.
   // The signed result is registered as the FSM enters DONE.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         dividend_q <= '0;
         divisor_q  <= '0;
         remPart_q  <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         quot_q     <= '0;
         remOut_q   <= '0;
         divZero_q  <= 1'b0;
      end else if (acceptFire) begin
         dividend_q <= dinMag;
         divisor_q  <= din1;
         remPart_q  <= '0;
         cnt_q      <= CNT_INIT;
         neg_q      <= din0[DIN0_WIDTH-1];
         if (din1 == '0) begin
            quot_q    <= satQuot;
            remOut_q  <= '0;
            divZero_q <= 1'b1;
         end
      end else if (state_q == CALC) begin
         dividend_q <= dividendStep;
         remPart_q  <= remStep;
         cnt_q      <= cnt_q - CW'(1);
         if (cnt_q == '0) begin
            quot_q    <= neg_q ? -dividendStep : dividendStep;
            remOut_q  <= neg_q ? -remStep : remStep;
            divZero_q <= 1'b0;
         end
      end
   end

   assign quot     = quot_q;
   assign rem      = remOut_q;
   assign div_zero = divZero_q;

endmodule

// File: tb/tb_pool_div_32s_16u_seq.sv
// tb_pool_div_32s_16u_seq
// Directed vectors with hand-computed quotient, remainder and latency.
// Extra sequences cover back-pressure and reset during a division.

module tb_pool_div_32s_16u_seq;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [31:0] din0;
   logic [15:0] din1;
   logic        outValid;
   logic        outReady;
   logic [31:0] quot;
   logic [16:0] rem;
   logic        divZero;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic [31:0] a;
      logic [15:0] b;
      logic [31:0] q;
      logic [16:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vec[13];

   pool_div_32s_16u_seq #(
      .ID(1),
      .DIN0_WIDTH(32),
      .DIN1_WIDTH(16)
   ) dut (
      .ap_clk(clk),
      .ap_rst(rst),
      .in_valid(inValid),
      .in_ready(inReady),
      .din0(din0),
      .din1(din1),
      .out_valid(outValid),
      .out_ready(outReady),
      .quot(quot),
      .rem(rem),
      .div_zero(divZero)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and count the result.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present operands while idle, let one edge accept them, then scramble the inputs.
   // The cycle count starts at 1 on the accept edge and grows until out_valid is seen.
   task automatic applyStimulus(input string name, input logic [31:0] a, input logic [15:0] b, output int lat);
      @(negedge clk);
      checkOutput({name, " in_ready idle"}, 32'(inReady), 32'd1);
      din0    = a;
      din1    = b;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      din0    = ~a;
      din1    = b + 16'd3;
      lat     = 1;
      while (!outValid && lat < 100) begin
         checkOutput({name, " in_ready busy"}, 32'(inReady), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Accept the result for one edge and confirm the divider returns to idle.
   task automatic ackResult(input string name);
      @(negedge clk);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput({name, " out_valid drop"}, 32'(outValid), 32'd0);
      checkOutput({name, " in_ready back"}, 32'(inReady), 32'd1);
   endtask

   initial begin
      int    lat;
      bit    stable;
      bit    sawValid;
      string nm;

      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      inValid     = 1'b0;
      outReady    = 1'b0;
      din0        = '0;
      din1        = '0;

      vec[0]  = '{32'd100,        16'd7,      32'd14,         17'd2,          1'b0, 33};
      vec[1]  = '{-32'sd100,      16'd7,      -32'sd14,       -17'sd2,        1'b0, 33};
      vec[2]  = '{32'd99,         16'd9,      32'd11,         17'd0,          1'b0, 33};
      vec[3]  = '{32'h8000_0000,  16'd1,      32'h8000_0000,  17'd0,          1'b0, 33};
      vec[4]  = '{32'h7FFF_FFFF,  16'hFFFF,   32'd32768,      17'd32767,      1'b0, 33};
      vec[5]  = '{32'd5,          16'd0,      32'h7FFF_FFFF,  17'd0,          1'b1, 1};
      vec[6]  = '{-32'sd5,        16'd0,      32'h8000_0000,  17'd0,          1'b1, 1};
      vec[7]  = '{-32'sd7,        16'd2,      -32'sd3,        -17'sd1,        1'b0, 33};
      vec[8]  = '{32'd0,          16'd5,      32'd0,          17'd0,          1'b0, 33};
      vec[9]  = '{-32'sd1,        16'hFFFF,   32'd0,          -17'sd1,        1'b0, 33};
      vec[10] = '{32'd12345678,   16'd1000,   32'd12345,      17'd678,        1'b0, 33};
      vec[11] = '{32'h8000_0000,  16'hFFFF,   -32'sd32768,    -17'sd32768,    1'b0, 33};
      vec[12] = '{32'd1000,       16'd10,     32'd100,        17'd0,          1'b0, 33};

      // Reset values while reset is held.
      #12;
      checkOutput("reset in_ready", 32'(inReady), 32'd1);
      checkOutput("reset out_valid", 32'(outValid), 32'd0);
      checkOutput("reset quot", quot, 32'd0);
      checkOutput("reset rem", 32'(rem), 32'd0);
      checkOutput("reset div_zero", 32'(divZero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 13; i++) begin
         nm = $sformatf("v%0d", i);
         applyStimulus(nm, vec[i].a, vec[i].b, lat);
         checkOutput({nm, " latency"}, 32'(lat), 32'(vec[i].lat));
         checkOutput({nm, " quot"}, quot, vec[i].q);
         checkOutput({nm, " rem"}, 32'(rem), 32'(vec[i].r));
         checkOutput({nm, " div_zero"}, 32'(divZero), 32'(vec[i].dz));
         ackResult(nm);
      end

      // Back-pressure: 1000/7 = 142 r 6 held for 10 cycles while busy-time in_valid is ignored.
      applyStimulus("bp", 32'd1000, 16'd7, lat);
      checkOutput("bp latency", 32'(lat), 32'd33);
      stable = 1'b1;
      @(negedge clk);
      inValid = 1'b1;
      din0    = 32'd999;
      din1    = 16'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (!outValid || inReady || quot !== 32'd142 || rem !== 17'd6 || divZero !== 1'b0) begin
            stable = 1'b0;
         end
      end
      checkOutput("bp hold stable", 32'(stable), 32'd1);
      @(negedge clk);
      outReady = 1'b1;
      din0     = 32'd77;
      din1     = 16'd5;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput("bp handshake out_valid", 32'(outValid), 32'd0);
      checkOutput("bp no fall-through", 32'(inReady), 32'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("bp next accepted", 32'(inReady), 32'd0);
      lat = 1;
      while (!outValid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("bp next latency", 32'(lat), 32'd33);
      checkOutput("bp next quot", quot, 32'd15);
      checkOutput("bp next rem", 32'(rem), 32'd2);
      ackResult("bp next");

      // Reset between edges at CALC cycle 10 aborts the division.
      @(negedge clk);
      din0    = 32'd100;
      din1    = 16'd7;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      for (int c = 0; c < 9; c++) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("abort in_ready", 32'(inReady), 32'd1);
      checkOutput("abort out_valid", 32'(outValid), 32'd0);
      checkOutput("abort quot", quot, 32'd0);
      checkOutput("abort rem", 32'(rem), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sawValid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (outValid) sawValid = 1'b1;
      end
      checkOutput("abort no out_valid", 32'(sawValid), 32'd0);
      applyStimulus("after", 32'd1000, 16'd10, lat);
      checkOutput("after latency", 32'(lat), 32'd33);
      checkOutput("after quot", quot, 32'd100);
      checkOutput("after rem", 32'(rem), 32'd0);
      ackResult("after");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
